// File: rtl/banco_reg_pkg.sv
// Shared types and sizes for the banco_reg register file.
//   WIDTH  : data width of each register and of the read/write data ports
//   DEPTH  : number of registers (power of two)
//   AW     : address width, derived from DEPTH
//   word_t : one register / data-port word
//   addr_t : one register address
package banco_reg_pkg;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned AW    = $clog2(DEPTH);

    typedef logic [WIDTH-1:0] word_t;
    typedef logic [AW-1:0]    addr_t;

endpackage : banco_reg_pkg

// File: rtl/banco_reg.sv
// banco_reg: 8 x 8-bit register file beside the ALU.
// Two combinational read ports and one synchronous write port.
// Register 0 is a real flop that is cleared by reset and never written,
// so it always reads zero yet stays visible in regs[0].
// Ports:
//   clk   in   rising-edge clock for all state
//   reset in   synchronous active-high clear of every register (beats a write)
//   we3   in   write enable for port 3
//   wa3   in   write address (writes to address 0 are discarded)
//   wd3   in   write data
//   ra1   in   read address, port 1
//   ra2   in   read address, port 2
//   rd1   out  regs[ra1], zero latency, no write bypass
//   rd2   out  regs[ra2], zero latency, no write bypass
module banco_reg
    import banco_reg_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             we3,
    input  logic [AW-1:0]    wa3,
    input  logic [WIDTH-1:0] wd3,
    input  logic [AW-1:0]    ra1,
    input  logic [AW-1:0]    ra2,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2
);

    // Register storage; regs[0] only ever receives the reset value.
    word_t regs [0:DEPTH-1];

    // Write qualifier: enabled and not targeting the hardwired-zero slot.
    logic wr_en_c;
    assign wr_en_c = we3 && (wa3 != '0);

    // Reset clears everything and takes priority over a same-edge write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en_c) begin
            regs[wa3] <= wd3;
        end
    end

    // Asynchronous reads: a same-cycle write becomes visible only after the edge.
    assign rd1 = regs[ra1];
    assign rd2 = regs[ra2];

endmodule : banco_reg

// File: tb/tb_banco_reg.sv
// Directed and random self-checking bench for banco_reg.
module tb_banco_reg;
    import banco_reg_pkg::*;

    logic  clk = 1'b0;
    logic  reset;
    logic  we3;
    addr_t wa3;
    word_t wd3;
    addr_t ra1;
    addr_t ra2;
    word_t rd1;
    word_t rd2;

    word_t model [0:DEPTH-1];
    int    passed = 0;
    int    total  = 0;

    banco_reg dut (
        .clk   (clk),
        .reset (reset),
        .we3   (we3),
        .wa3   (wa3),
        .wd3   (wd3),
        .ra1   (ra1),
        .ra2   (ra2),
        .rd1   (rd1),
        .rd2   (rd2)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single write cycle; model follows the reg0 discard rule.
    task automatic do_write(input addr_t a, input word_t d);
        we3 = 1'b1;
        wa3 = a;
        wd3 = d;
        tick();
        we3 = 1'b0;
        if (a != '0) model[a] = d;
    endtask

    task automatic test_reset();
        do_write(3'd3, 8'hA5);
        ra1 = 3'd3;
        #1;
        total++;
        if (rd1 !== 8'hA5) $display("FAIL reset_prewrite rd1=%h want=%h", rd1, 8'hA5);
        else passed++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) model[i] = 8'h00;
        for (int i = 0; i < int'(DEPTH); i++) begin
            total++;
            if (dut.regs[i] !== 8'h00) $display("FAIL reset_regs[%0d] got=%h want=00", i, dut.regs[i]);
            else passed++;
        end
        #1;
        total++;
        if (rd1 !== 8'h00) $display("FAIL reset_rd1 rd1=%h want=00", rd1);
        else passed++;
    endtask

    task automatic test_write_read();
        do_write(3'd1, 8'h12);
        do_write(3'd7, 8'hE7);
        do_write(3'd5, 8'h3C);
        ra1 = 3'd5;
        ra2 = 3'd5;
        #1;
        total++;
        if (rd1 !== 8'h3C) $display("FAIL wr_rd1 rd1=%h want=3c", rd1);
        else passed++;
        total++;
        if (rd2 !== 8'h3C) $display("FAIL wr_rd2 rd2=%h want=3c", rd2);
        else passed++;
        for (int i = 0; i < int'(DEPTH); i++) begin
            total++;
            if (dut.regs[i] !== model[i]) $display("FAIL wr_other[%0d] got=%h want=%h", i, dut.regs[i], model[i]);
            else passed++;
        end
        ra1 = 3'd1;
        ra2 = 3'd7;
        #1;
        total++;
        if (rd1 !== 8'h12 || rd2 !== 8'hE7) $display("FAIL wr_dual rd1=%h rd2=%h want=12/e7", rd1, rd2);
        else passed++;
    endtask

    task automatic test_reg0();
        do_write(3'd0, 8'hFF);
        ra1 = 3'd0;
        #1;
        total++;
        if (dut.regs[0] !== 8'h00) $display("FAIL reg0_store got=%h want=00", dut.regs[0]);
        else passed++;
        total++;
        if (rd1 !== 8'h00) $display("FAIL reg0_rd1 rd1=%h want=00", rd1);
        else passed++;
    endtask

    task automatic test_enable_off();
        do_write(3'd2, 8'h11);
        we3 = 1'b0;
        wa3 = 3'd2;
        wd3 = 8'h77;
        ra2 = 3'd2;
        repeat (4) tick();
        total++;
        if (dut.regs[2] !== 8'h11) $display("FAIL en_off_store got=%h want=11", dut.regs[2]);
        else passed++;
        total++;
        if (rd2 !== 8'h11) $display("FAIL en_off_rd2 rd2=%h want=11", rd2);
        else passed++;
    endtask

    task automatic test_read_during_write();
        do_write(3'd6, 8'h42);
        we3 = 1'b1;
        wa3 = 3'd6;
        wd3 = 8'h99;
        ra1 = 3'd6;
        #1;
        total++;
        if (rd1 !== 8'h42) $display("FAIL rdw_before rd1=%h want=42", rd1);
        else passed++;
        tick();
        we3 = 1'b0;
        model[6] = 8'h99;
        total++;
        if (rd1 !== 8'h99) $display("FAIL rdw_after rd1=%h want=99", rd1);
        else passed++;
    endtask

    // Random traffic against the model: reads checked before each edge, the written slot after.
    task automatic test_random();
        for (int n = 0; n < 10000; n++) begin
            we3 = 1'b1;
            wa3 = addr_t'($urandom_range(DEPTH - 1, 0));
            wd3 = word_t'($urandom);
            ra1 = addr_t'($urandom_range(DEPTH - 1, 0));
            ra2 = addr_t'($urandom_range(DEPTH - 1, 0));
            #1;
            total++;
            if (rd1 !== model[ra1] || rd2 !== model[ra2])
                $display("FAIL rand_read n=%0d ra1=%0d rd1=%h want=%h ra2=%0d rd2=%h want=%h",
                         n, ra1, rd1, model[ra1], ra2, rd2, model[ra2]);
            else passed++;
            tick();
            if (wa3 != '0) model[wa3] = wd3;
            total++;
            if (dut.regs[wa3] !== model[wa3] || dut.regs[0] !== 8'h00)
                $display("FAIL rand_write n=%0d wa3=%0d got=%h want=%h reg0=%h",
                         n, wa3, dut.regs[wa3], model[wa3], dut.regs[0]);
            else passed++;
        end
        we3 = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            total++;
            if (dut.regs[i] !== model[i]) $display("FAIL rand_final[%0d] got=%h want=%h", i, dut.regs[i], model[i]);
            else passed++;
        end
    endtask

    task automatic test_reset_priority();
        do_write(3'd4, 8'h33);
        reset = 1'b1;
        we3   = 1'b1;
        wa3   = 3'd4;
        wd3   = 8'h5A;
        tick();
        reset = 1'b0;
        we3   = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) model[i] = 8'h00;
        ra1 = 3'd4;
        #1;
        total++;
        if (dut.regs[4] !== 8'h00) $display("FAIL rst_prio_store got=%h want=00", dut.regs[4]);
        else passed++;
        total++;
        if (rd1 !== 8'h00) $display("FAIL rst_prio_rd1 rd1=%h want=00", rd1);
        else passed++;
    endtask

    initial begin
        reset = 1'b1;
        we3   = 1'b0;
        wa3   = '0;
        wd3   = '0;
        ra1   = '0;
        ra2   = '0;
        for (int i = 0; i < int'(DEPTH); i++) model[i] = 8'h00;
        repeat (2) tick();
        reset = 1'b0;
        test_reset();
        test_write_read();
        test_reg0();
        test_enable_off();
        test_read_during_write();
        test_random();
        test_reset_priority();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_banco_reg
